// File: rtl/spi_crypto_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_crypto_master: shifts {msg,key} to one of N_CH slaves, waits for done, |
// | then shifts the block-wide result back.              Revision: 1.0         |
// +----------------------------------------------------------------------------+
module spi_crypto_master #(
  parameter int NB      = 4,
  parameter int NK      = 8,
  parameter int N_CH    = 2,
  parameter int CHW     = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHW-1:0]    ch_sel,
  input  logic [32*NB-1:0]  msg_in,
  input  logic [32*NK-1:0]  key_in,
  input  logic              miso,
  input  logic [N_CH-1:0]   data_done,
  output logic              out_clk,
  output logic [N_CH-1:0]   cs_n,
  output logic              mosi,
  output logic              mosi_oe,
  output logic [32*NB-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              cfg_err
);
  localparam int TX_W  = 32*NB + 32*NK;
  localparam int RX_W  = 32*NB;
  localparam int MAXC  = (TX_W > TIMEOUT) ? TX_W : TIMEOUT;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t            state_q, state_d;
  logic [TX_W-1:0]   sh_q, sh_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;
  logic              cerr_q, cerr_d;
  logic [N_CH-1:0]   ch_hot;
  logic              ch_ok;
  logic              done_sel;
  logic              link_active;

  always_comb begin
    ch_hot = '0;
    for (int i = 0; i < N_CH; i++) ch_hot[i] = (ch_q == CHW'(i));
  end

  assign ch_ok       = (32'(ch_sel) < 32'(N_CH));
  assign done_sel    = |(data_done & ch_hot);
  assign link_active = (state_q == SEND) || (state_q == WAIT) || (state_q == RECV);

  assign out_clk      = in_clk;
  assign busy         = (state_q != IDLE);
  assign mosi_oe      = (state_q == SEND);
  assign mosi         = mosi_oe & sh_q[TX_W-1];
  assign cs_n         = link_active ? ~ch_hot : '1;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;
  assign cfg_err      = cerr_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    terr_d   = 1'b0;
    cerr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ch_ok) begin
            sh_d    = {msg_in, key_in};
            ch_d    = ch_sel;
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      SEND: begin
        sh_d = {sh_q[TX_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(TX_W - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        // A done seen on the last allowed cycle still wins over the timeout.
        if (done_sel) begin
          cnt_d   = '0;
          state_d = RECV;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        sh_d = {sh_q[TX_W-2:0], miso};
        if (cnt_q == CNT_W'(RX_W - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        result_d = sh_q[RX_W-1:0];
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
      cerr_q   <= cerr_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_crypto_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_crypto_master: directed checks of spi_crypto_master (NK=8 and NK=4).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_crypto_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] MSG_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RX_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RX_A2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] MSG_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RX_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  // DUT A: NK=8, CHW=2 so an out-of-range channel can be requested, short timeout
  logic         a_rst = 1'b0, a_start = 1'b0, a_miso = 1'b0;
  logic [1:0]   a_ch = '0, a_done = '0;
  logic [127:0] a_msg = '0;
  logic [255:0] a_key = '0;
  logic         a_out_clk, a_mosi, a_mosi_oe, a_valid, a_busy, a_terr, a_cerr;
  logic [1:0]   a_cs_n;
  logic [127:0] a_result;

  spi_crypto_master #(.NB(4), .NK(8), .N_CH(2), .CHW(2), .TIMEOUT(16)) dut_a (
    .in_clk(clk), .rst(a_rst), .start(a_start), .ch_sel(a_ch), .msg_in(a_msg),
    .key_in(a_key), .miso(a_miso), .data_done(a_done), .out_clk(a_out_clk),
    .cs_n(a_cs_n), .mosi(a_mosi), .mosi_oe(a_mosi_oe), .result(a_result),
    .result_valid(a_valid), .busy(a_busy), .timeout_err(a_terr), .cfg_err(a_cerr)
  );

  // DUT B: NK=4 build
  logic         b_rst = 1'b0, b_start = 1'b0, b_miso = 1'b0;
  logic [0:0]   b_ch = '0;
  logic [1:0]   b_done = '0;
  logic [127:0] b_msg = '0;
  logic [127:0] b_key = '0;
  logic         b_out_clk, b_mosi, b_mosi_oe, b_valid, b_busy, b_terr, b_cerr;
  logic [1:0]   b_cs_n;
  logic [127:0] b_result;

  spi_crypto_master #(.NB(4), .NK(4), .N_CH(2), .CHW(1), .TIMEOUT(1024)) dut_b (
    .in_clk(clk), .rst(b_rst), .start(b_start), .ch_sel(b_ch), .msg_in(b_msg),
    .key_in(b_key), .miso(b_miso), .data_done(b_done), .out_clk(b_out_clk),
    .cs_n(b_cs_n), .mosi(b_mosi), .mosi_oe(b_mosi_oe), .result(b_result),
    .result_valid(b_valid), .busy(b_busy), .timeout_err(b_terr), .cfg_err(b_cerr)
  );

  int a_vcnt = 0, a_tcnt = 0, b_vcnt = 0;
  always @(negedge clk) begin
    if (a_valid === 1'b1) a_vcnt++;
    if (a_terr === 1'b1) a_tcnt++;
    if (b_valid === 1'b1) b_vcnt++;
  end

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer on DUT A: w = number of WAIT cycles before done is sampled.
  task automatic xfer_a(input logic [1:0] ch, input logic [127:0] msg,
                        input logic [255:0] key, input logic [127:0] rx, input int w);
    logic [383:0] cap;
    logic [1:0]   exp_cs;
    int bad;
    exp_cs = ~(2'b01 << ch);
    bad = 0;
    cap = '0;
    @(negedge clk);
    a_start = 1'b1; a_ch = ch; a_msg = msg; a_key = key;
    for (int i = 0; i < 384; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      cap[383-i] = a_mosi;
      if (a_cs_n !== exp_cs || a_mosi_oe !== 1'b1 || a_busy !== 1'b1) bad++;
    end
    chk("a_tx_bits", cap, {msg, key});
    chk("a_send_ctl", bad, 0);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (a_cs_n !== exp_cs || a_mosi_oe !== 1'b0 || a_mosi !== 1'b0 || a_busy !== 1'b1) bad++;
      if (k == w) a_done[ch] = 1'b1;
    end
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      a_done = '0;
      a_miso = rx[127-j];
      if (a_cs_n !== exp_cs || a_valid !== 1'b0) bad++;
    end
    chk("a_wait_recv_ctl", bad, 0);
    @(negedge clk);
    a_miso = 1'b0;
    chk("a_done_busy", a_busy, 1);
    chk("a_done_cs", a_cs_n, 2'b11);
    chk("a_done_novalid", a_valid, 0);
    @(negedge clk);
    chk("a_valid_pulse", a_valid, 1);
    chk("a_result", a_result, rx);
    chk("a_idle_busy", a_busy, 0);
    @(negedge clk);
    chk("a_valid_end", a_valid, 0);
    chk("a_result_hold", a_result, rx);
  endtask

  initial begin
    logic [383:0] capb;
    int bad;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", a_cs_n, 2'b11);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_oe", a_mosi_oe, 0);
    chk("rst_result", a_result, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_errs", {a_terr, a_cerr}, 0);
    chk("out_clk", a_out_clk, clk);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // Main transfer, channel 0, done on 5th WAIT cycle: valid at cycle 519
    xfer_a(2'd0, MSG_A, KEY_A, RX_A, 5);
    chk("a_vcnt1", a_vcnt, 1);

    // Timeout on channel 1
    @(negedge clk);
    a_start = 1'b1; a_ch = 2'd1; a_msg = ~MSG_A; a_key = ~KEY_A;
    @(negedge clk);
    a_start = 1'b0;
    chk("to_cs_ch1", a_cs_n, 2'b01);
    repeat (383) @(negedge clk);
    for (int k = 1; k <= 16; k++) @(negedge clk);
    chk("to_last_wait_busy", a_busy, 1);
    chk("to_last_wait_noerr", a_terr, 0);
    @(negedge clk);
    chk("to_err", a_terr, 1);
    chk("to_busy", a_busy, 0);
    chk("to_cs", a_cs_n, 2'b11);
    chk("to_result", a_result, RX_A);
    @(negedge clk);
    chk("to_err_end", a_terr, 0);
    chk("to_count", a_tcnt, 1);
    chk("to_novalid", a_vcnt, 1);

    // Out-of-range channel
    a_start = 1'b1; a_ch = 2'd3;
    @(negedge clk);
    a_start = 1'b0;
    chk("cfg_err", a_cerr, 1);
    chk("cfg_busy", a_busy, 0);
    chk("cfg_cs", a_cs_n, 2'b11);
    @(negedge clk);
    chk("cfg_err_end", a_cerr, 0);
    chk("cfg_busy2", a_busy, 0);

    // Asynchronous reset in the middle of SEND
    a_start = 1'b1; a_ch = 2'd0; a_msg = MSG_A; a_key = KEY_A;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    chk("mid_send_oe", a_mosi_oe, 1);
    #2 a_rst = 1'b0;
    #1;
    chk("arst_cs", a_cs_n, 2'b11);
    chk("arst_mosi", {a_mosi, a_mosi_oe}, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_result", a_result, 0);
    chk("arst_valid", a_valid, 0);
    @(negedge clk);
    a_rst = 1'b1;
    xfer_a(2'd0, MSG_A, KEY_A, RX_A2, 3);
    chk("a_vcnt2", a_vcnt, 2);

    // NK=4: re-pulsed start while busy and a foreign done are ignored
    bad = 0;
    capb = '0;
    @(negedge clk);
    b_start = 1'b1; b_ch = 1'b0; b_msg = MSG_B; b_key = KEY_B;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      b_start = (i == 10);
      if (i == 10) begin b_ch = 1'b1; b_msg = ~MSG_B; b_key = ~KEY_B; end
      if (i == 20) b_done = 2'b10;
      capb[255-i] = b_mosi;
      if (b_cs_n !== 2'b10 || b_mosi_oe !== 1'b1) bad++;
    end
    chk("b_tx_bits", capb[255:0], {MSG_B, KEY_B});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (b_cs_n !== 2'b10 || b_busy !== 1'b1 || b_mosi_oe !== 1'b0) bad++;
      if (k == 4) b_done = 2'b11;
    end
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      b_done = '0;
      b_miso = RX_B[127-j];
      if (b_cs_n !== 2'b10 || b_valid !== 1'b0) bad++;
    end
    chk("b_ctl", bad, 0);
    @(negedge clk);
    b_miso = 1'b0;
    chk("b_done_novalid", b_valid, 0);
    @(negedge clk);
    chk("b_valid_390", b_valid, 1);
    chk("b_result", b_result, RX_B);
    chk("b_busy_end", b_busy, 0);
    repeat (3) @(negedge clk);
    chk("b_vcnt", b_vcnt, 1);
    chk("b_no_errs", {b_terr, b_cerr, b_out_clk}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_crypto_master.md
Name: spi_crypto_master

Overview:
- Parametrised serial master for the AES encrypt/decrypt subnodes. It replaces the fixed single-pair master.
- Shifts {message, key} MSB-first on mosi to one of N_CH slave channels, then waits for that channel's done strobe and shifts the 128-bit result back from miso.
- Start/busy/valid handshake and a done-timeout; sits between the host-side registers and the slave chain.

Parameters:
NB, 4, state columns; block width = 32*NB bits
NK, 8, key words (legal 4, 6, 8); key width = 32*NK bits
N_CH, 2, number of slave channels (chip selects), >=1
CHW, 1, width of channel select, >= clog2(N_CH), >=1
TIMEOUT, 1024, max in_clk cycles spent in WAIT before error

Ports:
in_clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; accepted only when busy=0
ch_sel  input  CHW  target channel, sampled with start
msg_in  input  32*NB  plaintext/ciphertext, sampled with start
key_in  input  32*NK  key, sampled with start
miso  input  1  serial result from slaves
data_done  input  N_CH  per-channel done level from slaves
out_clk  output  1  = in_clk (pass-through)
cs_n  output  N_CH  active-low chip selects, at most one low
mosi  output  1  serial data to slaves
mosi_oe  output  1  1 while SEND, else 0
result  output  32*NB  received block
result_valid  output  1  one-cycle pulse, result updated
busy  output  1  transaction in progress
timeout_err  output  1  one-cycle pulse on WAIT timeout
cfg_err  output  1  one-cycle pulse on start with ch_sel>=N_CH

Behaviour:
- Reset (rst=0, async): state IDLE, cs_n all 1, mosi=0, mosi_oe=0, result=0, result_valid=0, busy=0, both err=0, counters 0. Reset mid-transfer aborts immediately; no partial result_valid.
- TX_W = 32*NB+32*NK, RX_W = 32*NB.
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: start=1 with ch_sel<N_CH latches {msg_in,key_in} into the shift register and latches ch. Next cycle: SEND, busy=1, cs_n[ch]=0.
- IDLE: start=1 with ch_sel>=N_CH gives cfg_err=1 next cycle only; state stays IDLE.
- start while busy=1 is ignored.
- SEND: first SEND cycle, mosi = bit TX_W-1 (message MSB); one bit per cycle; last bit (key LSB) on the TX_W-th SEND cycle; then WAIT.
- WAIT: mosi=0, mosi_oe=0, cs_n[ch] stays 0. Sampling data_done[ch]=1 moves to RECV next cycle. Other channels' data_done are ignored.
- WAIT timeout: TIMEOUT cycles in WAIT without done → IDLE, cs_n all 1, busy=0, timeout_err=1 for one cycle; result unchanged.
- data_done[ch] already 1 on the first WAIT cycle counts as done.
- RECV: miso sampled on RX_W consecutive edges, shifted in LSB-side (first sample ends as MSB); then DONE.
- DONE (1 cycle): result <= shift register, result_valid=1, cs_n all 1. Next cycle IDLE, busy=0.
- result holds until the next DONE or reset.
- Latency start→result_valid = 1+TX_W+W+RX_W+1 cycles, where W = WAIT cycles (>=1).
- Counters sized for max(TX_W, TIMEOUT); no wrap-around inside a state.
- busy=1 from the cycle after accept through DONE inclusive.

Test Plan:
- NK=8, N_CH=2, ch_sel=0, msg=0x00112233445566778899aabbccddeeff, key=0x000102..1f → mosi shows 384 bits MSB-first; cs_n=2'b10 throughout; cs_n[1] stays 1.
- data_done[0] high 5 cycles after SEND ends, miso drives 0x69c4e0d86a7b0430d8cdb78070b4c55a MSB-first → result equals that value; result_valid pulses exactly once at cycle 1+384+5+128+1 after start.
- TIMEOUT=16, data_done never asserted → after 16 WAIT cycles timeout_err pulses once, cs_n=2'b11, busy=0, result unchanged.
- ch_sel=3 with N_CH=2 → cfg_err pulses once; busy stays 0; cs_n stays 2'b11.
- rst driven low at SEND bit 100, then released → all outputs at reset values asynchronously; a new start then runs a full clean transfer.
- NK=4 build, start re-pulsed while busy, data_done[1] asserted while ch=0 → 256-bit TX; extra start and foreign done ignored; single result_valid.
